// File: rtl/mem_seq.sv
// Memory access sequencer for the z0 CPU: turns LOAD/STORE opcodes into a single
// req/ack bus transaction, pulses is_loaded on completion and latches a sticky timeout fault.
module mem_seq #(
   parameter logic [7:0] OP_LOAD  = 8'h02,
   parameter logic [7:0] OP_STORE = 8'h03,
   parameter int         TIMEOUT  = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] instruction,
   input  logic [15:0] mar,
   input  logic [15:0] mdr,
   output logic [15:0] load_to_mdr,
   output logic        is_loaded,
   output logic        mem_fault,
   output logic        mem_req,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   input  logic        mem_ack
);

   typedef enum logic [1:0] {IDLE, REQ, DONE, FAULT} state_t;

   // Wait count of the final REQ cycle in which an ack is still accepted.
   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [7:0]  wait_q, wait_d;
   logic [15:0] load_to_mdr_q, load_to_mdr_d;
   logic        is_loaded_q, is_loaded_d;
   logic        mem_fault_q, mem_fault_d;
   logic        mem_req_q, mem_req_d;
   logic        mem_we_q, mem_we_d;
   logic [15:0] mem_addr_q, mem_addr_d;
   logic [15:0] mem_wdata_q, mem_wdata_d;

   logic [7:0]  opcode;
   logic        unused_operand;

   assign opcode         = instruction[15:8];
   assign unused_operand = ^instruction[7:0];

   always_comb begin
      state_d       = state_q;
      wait_d        = wait_q;
      load_to_mdr_d = load_to_mdr_q;
      is_loaded_d   = 1'b0;
      mem_fault_d   = mem_fault_q;
      mem_req_d     = mem_req_q;
      mem_we_d      = mem_we_q;
      mem_addr_d    = mem_addr_q;
      mem_wdata_d   = mem_wdata_q;

      unique case (state_q)
         IDLE: begin
            mem_req_d = 1'b0;
            if (opcode == OP_LOAD) begin
               mem_addr_d = mar;
               mem_we_d   = 1'b0;
               mem_req_d  = 1'b1;
               wait_d     = 8'd0;
               state_d    = REQ;
            end else if (opcode == OP_STORE) begin
               mem_addr_d  = mar;
               mem_wdata_d = mdr;
               mem_we_d    = 1'b1;
               mem_req_d   = 1'b1;
               wait_d      = 8'd0;
               state_d     = REQ;
            end
         end
         REQ: begin
            if (mem_ack) begin
               if (!mem_we_q) begin
                  load_to_mdr_d = mem_rdata;
               end
               mem_req_d   = 1'b0;
               is_loaded_d = 1'b1;
               state_d     = DONE;
            end else if (wait_q == WAIT_LAST) begin
               mem_req_d   = 1'b0;
               mem_fault_d = 1'b1;
               state_d     = FAULT;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end
         DONE: begin
            // The completing cycle never decodes, so each opcode gets its own transaction.
            mem_req_d = 1'b0;
            state_d   = IDLE;
         end
         FAULT: begin
            mem_req_d   = 1'b0;
            mem_fault_d = 1'b1;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         wait_q        <= 8'd0;
         load_to_mdr_q <= 16'd0;
         is_loaded_q   <= 1'b0;
         mem_fault_q   <= 1'b0;
         mem_req_q     <= 1'b0;
         mem_we_q      <= 1'b0;
         mem_addr_q    <= 16'd0;
         mem_wdata_q   <= 16'd0;
      end else begin
         state_q       <= state_d;
         wait_q        <= wait_d;
         load_to_mdr_q <= load_to_mdr_d;
         is_loaded_q   <= is_loaded_d;
         mem_fault_q   <= mem_fault_d;
         mem_req_q     <= mem_req_d;
         mem_we_q      <= mem_we_d;
         mem_addr_q    <= mem_addr_d;
         mem_wdata_q   <= mem_wdata_d;
      end
   end

   assign load_to_mdr = load_to_mdr_q;
   assign is_loaded   = is_loaded_q;
   assign mem_fault   = mem_fault_q;
   assign mem_req     = mem_req_q;
   assign mem_we      = mem_we_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_mem_seq.sv
// Directed bench for mem_seq: one instance with the default timeout, one with TIMEOUT=4,
// both fed the same stimulus; inputs change and outputs are sampled on the falling edge.
module tb_mem_seq;

   localparam logic [15:0] I_NOP   = 16'h0000;
   localparam logic [15:0] I_LOAD  = 16'h0200;
   localparam logic [15:0] I_STORE = 16'h0300;
   localparam logic [15:0] I_OTHER = 16'h0577;

   logic        clk;
   logic        rst;
   logic [15:0] instruction;
   logic [15:0] mar;
   logic [15:0] mdr;
   logic [15:0] mem_rdata;
   logic        mem_ack;

   logic [15:0] load_a, addr_a, wdata_a;
   logic        isl_a, flt_a, req_a, we_a;
   logic [15:0] load_b, addr_b, wdata_b;
   logic        isl_b, flt_b, req_b, we_b;
   logic [3:0]  st_a, st_b;

   int total;
   int bad;

   assign st_a = {req_a, we_a, isl_a, flt_a};
   assign st_b = {req_b, we_b, isl_b, flt_b};

   mem_seq #(.TIMEOUT(16)) dut_a (
      .clk(clk), .rst(rst), .instruction(instruction), .mar(mar), .mdr(mdr),
      .load_to_mdr(load_a), .is_loaded(isl_a), .mem_fault(flt_a), .mem_req(req_a),
      .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wdata_a),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   mem_seq #(.TIMEOUT(4)) dut_b (
      .clk(clk), .rst(rst), .instruction(instruction), .mar(mar), .mdr(mdr),
      .load_to_mdr(load_b), .is_loaded(isl_b), .mem_fault(flt_b), .mem_req(req_b),
      .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wdata_b),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Leaves the bench at a falling edge just after the reset edge (cycle 0, IDLE).
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; instruction = I_NOP; mem_ack = 1'b0; mar = 16'h0; mdr = 16'h0; mem_rdata = 16'h0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if ({st_a, addr_a, wdata_a, load_a} !== 52'd0) begin
         bad++; $display("FAIL reset_a: got st=%b addr=%h wdata=%h load=%h, want all 0", st_a, addr_a, wdata_a, load_a);
      end
      total++;
      if ({st_b, addr_b, wdata_b, load_b} !== 52'd0) begin
         bad++; $display("FAIL reset_b: got st=%b addr=%h wdata=%h load=%h, want all 0", st_b, addr_b, wdata_b, load_b);
      end
   endtask

   task automatic test_load();
      do_reset();
      instruction = I_LOAD; mar = 16'h0040;
      @(negedge clk);
      total++;
      if (st_a !== 4'b1000 || addr_a !== 16'h0040) begin
         bad++; $display("FAIL load_req: got st=%b addr=%h, want 1000 0040", st_a, addr_a);
      end
      instruction = I_NOP; mem_ack = 1'b1; mem_rdata = 16'hBEEF;
      @(negedge clk);
      total++;
      if (req_a !== 1'b0 || isl_a !== 1'b1 || load_a !== 16'hBEEF) begin
         bad++; $display("FAIL load_done: got req=%b isl=%b load=%h, want 0 1 beef", req_a, isl_a, load_a);
      end
      mem_ack = 1'b0; mem_rdata = 16'h0000;
      @(negedge clk);
      total++;
      if (req_a !== 1'b0 || isl_a !== 1'b0 || load_a !== 16'hBEEF) begin
         bad++; $display("FAIL load_hold: got req=%b isl=%b load=%h, want 0 0 beef", req_a, isl_a, load_a);
      end
   endtask

   task automatic test_store();
      do_reset();
      instruction = I_STORE; mar = 16'h0100; mdr = 16'h1234;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         total++;
         if (st_a !== 4'b1100 || addr_a !== 16'h0100 || wdata_a !== 16'h1234) begin
            bad++; $display("FAIL store_req c%0d: got st=%b addr=%h wdata=%h, want 1100 0100 1234", c, st_a, addr_a, wdata_a);
         end
         instruction = I_NOP; mar = 16'hFFFF; mdr = 16'hAAAA;
         if (c == 5) begin
            mem_ack = 1'b1; mem_rdata = 16'hDEAD;
         end
      end
      @(negedge clk);
      total++;
      if (req_a !== 1'b0 || isl_a !== 1'b1 || flt_a !== 1'b0 || load_a !== 16'h0000) begin
         bad++; $display("FAIL store_done: got req=%b isl=%b flt=%b load=%h, want 0 1 0 0000", req_a, isl_a, flt_a, load_a);
      end
      mem_ack = 1'b0;
      @(negedge clk);
      total++;
      if (req_a !== 1'b0 || isl_a !== 1'b0 || load_a !== 16'h0000) begin
         bad++; $display("FAIL store_after: got req=%b isl=%b load=%h, want 0 0 0000", req_a, isl_a, load_a);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      instruction = I_LOAD; mar = 16'h0200;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         total++;
         if (st_b !== 4'b1000 || addr_b !== 16'h0200) begin
            bad++; $display("FAIL timeout_req c%0d: got st=%b addr=%h, want 1000 0200", c, st_b, addr_b);
         end
         instruction = I_NOP;
      end
      @(negedge clk);
      total++;
      if (req_b !== 1'b0 || isl_b !== 1'b0 || flt_b !== 1'b1) begin
         bad++; $display("FAIL timeout_fault: got req=%b isl=%b flt=%b, want 0 0 1", req_b, isl_b, flt_b);
      end
      mem_ack = 1'b1; mem_rdata = 16'h3333; instruction = I_LOAD;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         total++;
         if (req_b !== 1'b0 || isl_b !== 1'b0 || flt_b !== 1'b1 || load_b !== 16'h0000) begin
            bad++; $display("FAIL timeout_sticky c%0d: got req=%b isl=%b flt=%b load=%h, want 0 0 1 0000", c, req_b, isl_b, flt_b, load_b);
         end
      end
      mem_ack = 1'b0; instruction = I_NOP; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      total++;
      if (st_b !== 4'b0000) begin
         bad++; $display("FAIL timeout_clear: got st=%b, want 0000", st_b);
      end
   endtask

   task automatic test_boundary_ack();
      do_reset();
      instruction = I_LOAD; mar = 16'h0300;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         instruction = I_NOP;
         if (c == 4) begin
            total++;
            if (req_b !== 1'b1 || flt_b !== 1'b0) begin
               bad++; $display("FAIL boundary_req: got req=%b flt=%b, want 1 0", req_b, flt_b);
            end
            mem_ack = 1'b1; mem_rdata = 16'h5A5A;
         end
      end
      @(negedge clk);
      mem_ack = 1'b0;
      total++;
      if (req_b !== 1'b0 || isl_b !== 1'b1 || flt_b !== 1'b0 || load_b !== 16'h5A5A) begin
         bad++; $display("FAIL boundary_done: got req=%b isl=%b flt=%b load=%h, want 0 1 0 5a5a", req_b, isl_b, flt_b, load_b);
      end
      @(negedge clk);
      total++;
      if (flt_b !== 1'b0 || isl_b !== 1'b0) begin
         bad++; $display("FAIL boundary_after: got flt=%b isl=%b, want 0 0", flt_b, isl_b);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      instruction = I_LOAD; mar = 16'h0010;
      @(negedge clk);
      total++;
      if (req_a !== 1'b1 || addr_a !== 16'h0010 || isl_a !== 1'b0) begin
         bad++; $display("FAIL b2b_req1: got req=%b addr=%h isl=%b, want 1 0010 0", req_a, addr_a, isl_a);
      end
      mar = 16'h0011; mem_ack = 1'b1; mem_rdata = 16'h1111;
      @(negedge clk);
      total++;
      if (req_a !== 1'b0 || isl_a !== 1'b1 || load_a !== 16'h1111) begin
         bad++; $display("FAIL b2b_done1: got req=%b isl=%b load=%h, want 0 1 1111", req_a, isl_a, load_a);
      end
      mem_ack = 1'b0;
      @(negedge clk);
      total++;
      if (req_a !== 1'b0 || isl_a !== 1'b0) begin
         bad++; $display("FAIL b2b_gap: got req=%b isl=%b, want 0 0", req_a, isl_a);
      end
      @(negedge clk);
      total++;
      if (req_a !== 1'b1 || addr_a !== 16'h0011 || isl_a !== 1'b0) begin
         bad++; $display("FAIL b2b_req2: got req=%b addr=%h isl=%b, want 1 0011 0", req_a, addr_a, isl_a);
      end
      instruction = I_NOP; mem_ack = 1'b1; mem_rdata = 16'h2222;
      @(negedge clk);
      total++;
      if (req_a !== 1'b0 || isl_a !== 1'b1 || load_a !== 16'h2222) begin
         bad++; $display("FAIL b2b_done2: got req=%b isl=%b load=%h, want 0 1 2222", req_a, isl_a, load_a);
      end
      mem_ack = 1'b0; instruction = I_OTHER;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         total++;
         if (req_a !== 1'b0 || isl_a !== 1'b0) begin
            bad++; $display("FAIL nonmem_idle c%0d: got req=%b isl=%b, want 0 0", c, req_a, isl_a);
         end
      end
      instruction = I_NOP;
   endtask

   task automatic test_reset_mid_req();
      do_reset();
      instruction = I_LOAD; mar = 16'h0030;
      @(negedge clk);
      instruction = I_NOP; mem_ack = 1'b1; mem_rdata = 16'h7777;
      @(negedge clk);
      mem_ack = 1'b0;
      total++;
      if (isl_a !== 1'b1 || load_a !== 16'h7777) begin
         bad++; $display("FAIL mid_pre: got isl=%b load=%h, want 1 7777", isl_a, load_a);
      end
      @(negedge clk);
      instruction = I_LOAD; mar = 16'h0400;
      @(negedge clk);
      total++;
      if (req_a !== 1'b1 || addr_a !== 16'h0400) begin
         bad++; $display("FAIL mid_req: got req=%b addr=%h, want 1 0400", req_a, addr_a);
      end
      rst = 1'b1; instruction = I_NOP;
      @(negedge clk);
      rst = 1'b0;
      total++;
      if ({st_a, addr_a, wdata_a, load_a} !== 52'd0) begin
         bad++; $display("FAIL mid_reset: got st=%b addr=%h wdata=%h load=%h, want all 0", st_a, addr_a, wdata_a, load_a);
      end
      mem_ack = 1'b1; mem_rdata = 16'h4444;
      @(negedge clk);
      total++;
      if (st_a !== 4'b0000 || load_a !== 16'h0000) begin
         bad++; $display("FAIL mid_stray_ack: got st=%b load=%h, want 0000 0000", st_a, load_a);
      end
      mem_ack = 1'b0; instruction = I_LOAD; mar = 16'h0500;
      @(negedge clk);
      total++;
      if (req_a !== 1'b1 || addr_a !== 16'h0500 || we_a !== 1'b0) begin
         bad++; $display("FAIL mid_next_req: got req=%b addr=%h we=%b, want 1 0500 0", req_a, addr_a, we_a);
      end
      instruction = I_NOP; mem_ack = 1'b1; mem_rdata = 16'h9999;
      @(negedge clk);
      mem_ack = 1'b0;
      total++;
      if (isl_a !== 1'b1 || load_a !== 16'h9999) begin
         bad++; $display("FAIL mid_next_done: got isl=%b load=%h, want 1 9999", isl_a, load_a);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst = 1'b1; instruction = I_NOP; mar = 16'h0; mdr = 16'h0; mem_rdata = 16'h0; mem_ack = 1'b0;
      test_reset();
      test_load();
      test_store();
      test_timeout();
      test_boundary_ack();
      test_back_to_back();
      test_reset_mid_req();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
